// File: rtl/iob_axistream_out_w_pkg.sv
// Shared register map, control/status bit positions and helpers for the
// CPU-to-AXI-Stream word unpacker.
package iob_axistream_out_w_pkg;

    localparam int unsigned REG_DATA      = 0;
    localparam int unsigned REG_DATA_LAST = 1;
    localparam int unsigned REG_NBEATS    = 2;
    localparam int unsigned REG_CTRL      = 3;
    localparam int unsigned REG_STATUS    = 4;

    localparam int unsigned CTRL_ENABLE = 0;
    localparam int unsigned CTRL_CLEAR  = 1;

    localparam int unsigned STAT_FULL      = 0;
    localparam int unsigned STAT_EMPTY     = 1;
    localparam int unsigned STAT_BUSY      = 2;
    localparam int unsigned STAT_OVERFLOW  = 3;
    localparam int unsigned STAT_LEVEL_LSB = 16;

    localparam int unsigned NBEATS_W = 6;

    // A requested beat count of zero or beyond the word's beat capacity means "whole word".
    function automatic logic [NBEATS_W-1:0] resolve_nbeats(input logic [NBEATS_W-1:0] req,
                                                            input int unsigned ratio);
        if (req == '0 || 32'(req) > ratio)
            return NBEATS_W'(ratio);
        return req;
    endfunction

endpackage

// File: rtl/iob_axistream_out_w_if.sv
// CPU register port plus outgoing stream port of the word unpacker.
interface iob_axistream_out_w_if #(
    parameter int DATA_W  = 32,
    parameter int TDATA_W = 8,
    parameter int ADDR_W  = 3
);
    logic                  valid;
    logic [ADDR_W-1:0]     address;
    logic [DATA_W-1:0]     wdata;
    logic [DATA_W/8-1:0]   wstrb;
    logic [DATA_W-1:0]     rdata;
    logic                  ready;
    logic [TDATA_W-1:0]    tdata;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;

    modport slave (
        input  valid, address, wdata, wstrb, tready,
        output rdata, ready, tdata, tvalid, tlast
    );

    modport master (
        output valid, address, wdata, wstrb, tready,
        input  rdata, ready, tdata, tvalid, tlast
    );
endinterface

// File: rtl/iob_axistream_out_w_fifo.sv
// Show-ahead word FIFO: pop_data always presents the oldest entry while not empty.
module iob_axistream_out_w_fifo #(
    parameter int W          = 39,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  push,
    input  logic [W-1:0]          push_data,
    input  logic                  pop,
    output logic [W-1:0]          pop_data,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   level
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [W-1:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0]   wr_ptr;
    logic [DEPTH_LOG2-1:0]   rd_ptr;
    logic [DEPTH_LOG2:0]     count;
    logic                    do_push;
    logic                    do_pop;

    assign full     = (count == (DEPTH_LOG2+1)'(DEPTH));
    assign empty    = (count == '0);
    assign level    = count;
    assign pop_data = mem[rd_ptr];

    // A push into a full FIFO is fine when the same cycle frees a slot.
    assign do_pop  = pop & ~empty & ~clr;
    assign do_push = push & (~full | do_pop) & ~clr;

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (DEPTH_LOG2+1)'(1);
                2'b01:   count <= count - (DEPTH_LOG2+1)'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/iob_axistream_out_w.sv
// CPU-written words are queued and unpacked LSB-first into TDATA_W-wide stream beats.
//
// state | meaning
// IDLE  | no word held, tvalid low
// SEND  | word held, tvalid high, beats_left counts down to the final beat
module iob_axistream_out_w
    import iob_axistream_out_w_pkg::*;
#(
    parameter int DATA_W          = 32,
    parameter int TDATA_W         = 8,
    parameter int FIFO_DEPTH_LOG2 = 4,
    parameter int ADDR_W          = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    iob_axistream_out_w_if.slave   bus
);
    localparam int R  = DATA_W / TDATA_W;
    localparam int FW = DATA_W + 1 + NBEATS_W;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

    logic                     wr_en;
    logic                     rd_en;
    logic                     sel_data;
    logic                     sel_last;
    logic                     sel_nbeats;
    logic                     sel_ctrl;
    logic                     sel_status;
    logic                     clear;
    logic                     push;
    logic                     pop;
    logic [FW-1:0]            push_word;
    logic [FW-1:0]            fifo_q;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic [FIFO_DEPTH_LOG2:0] fifo_level;
    logic [DATA_W-1:0]        fifo_word;
    logic [NBEATS_W-1:0]      fifo_nb;
    logic                     fifo_last;

    logic [NBEATS_W-1:0]      nbeats_q;
    logic                     enable_q;
    logic                     overflow_q;
    logic                     ready_q;
    logic [DATA_W-1:0]        rdata_q;
    logic [DATA_W-1:0]        rd_mux;
    logic [31:0]              status;
    logic [31:0]              ctrl_rd;

    logic [0:0]               state_q;
    logic [DATA_W-1:0]        shift_q;
    logic [NBEATS_W-1:0]      beats_left;
    logic                     word_last;
    logic [TDATA_W-1:0]       tdata_q;
    logic                     tlast_q;
    logic                     accept;
    logic                     final_beat;

    assign wr_en      = bus.valid & (|bus.wstrb);
    assign rd_en      = bus.valid & ~(|bus.wstrb);
    assign sel_data   = (bus.address == ADDR_W'(REG_DATA));
    assign sel_last   = (bus.address == ADDR_W'(REG_DATA_LAST));
    assign sel_nbeats = (bus.address == ADDR_W'(REG_NBEATS));
    assign sel_ctrl   = (bus.address == ADDR_W'(REG_CTRL));
    assign sel_status = (bus.address == ADDR_W'(REG_STATUS));

    assign clear = wr_en & sel_ctrl & bus.wdata[CTRL_CLEAR];
    assign push  = wr_en & (sel_data | sel_last) & ~clear;

    assign push_word = {sel_last,
                        sel_last ? resolve_nbeats(nbeats_q, R) : NBEATS_W'(R),
                        bus.wdata};

    assign fifo_word = fifo_q[DATA_W-1:0];
    assign fifo_nb   = fifo_q[DATA_W +: NBEATS_W];
    assign fifo_last = fifo_q[FW-1];

    iob_axistream_out_w_fifo #(
        .W          (FW),
        .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (clear),
        .push       (push),
        .push_data  (push_word),
        .pop        (pop),
        .pop_data   (fifo_q),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .level      (fifo_level)
    );

    // Registers and sticky overflow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nbeats_q   <= '0;
            enable_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            if (wr_en && sel_nbeats)
                nbeats_q <= bus.wdata[NBEATS_W-1:0];
            if (wr_en && sel_ctrl)
                enable_q <= bus.wdata[CTRL_ENABLE];
            if (clear)
                overflow_q <= 1'b0;
            else if (push && fifo_full && !pop)
                overflow_q <= 1'b1;
        end
    end

    always_comb begin
        status                             = '0;
        status[STAT_FULL]                  = fifo_full;
        status[STAT_EMPTY]                 = fifo_empty;
        status[STAT_BUSY]                  = (state_q == ST_SEND);
        status[STAT_OVERFLOW]              = overflow_q;
        status[STAT_LEVEL_LSB +: 16]       = 16'(fifo_level);
        ctrl_rd                            = '0;
        ctrl_rd[CTRL_ENABLE]               = enable_q;
        rd_mux                             = '0;
        if (sel_nbeats)
            rd_mux = DATA_W'(nbeats_q);
        else if (sel_ctrl)
            rd_mux = DATA_W'(ctrl_rd);
        else if (sel_status)
            rd_mux = DATA_W'(status);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            ready_q <= bus.valid;
            rdata_q <= rd_en ? rd_mux : '0;
        end
    end

    assign bus.ready = ready_q;
    assign bus.rdata = rdata_q;

    // Unpacker: a new word is taken either from IDLE or as the final beat is accepted.
    assign accept     = (state_q == ST_SEND) & bus.tready;
    assign final_beat = (beats_left == '0);
    assign pop        = ~clear & enable_q & ~fifo_empty &
                        ((state_q == ST_IDLE) | (accept & final_beat));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            beats_left <= '0;
            word_last  <= 1'b0;
            tdata_q    <= '0;
            tlast_q    <= 1'b0;
        end else if (clear) begin
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            beats_left <= '0;
            word_last  <= 1'b0;
            tdata_q    <= '0;
            tlast_q    <= 1'b0;
        end else if (pop) begin
            state_q    <= ST_SEND;
            tdata_q    <= fifo_word[TDATA_W-1:0];
            shift_q    <= fifo_word >> TDATA_W;
            beats_left <= fifo_nb - NBEATS_W'(1);
            word_last  <= fifo_last;
            tlast_q    <= fifo_last & (fifo_nb == NBEATS_W'(1));
        end else if (accept) begin
            if (final_beat) begin
                state_q <= ST_IDLE;
                tlast_q <= 1'b0;
            end else begin
                tdata_q    <= shift_q[TDATA_W-1:0];
                shift_q    <= shift_q >> TDATA_W;
                beats_left <= beats_left - NBEATS_W'(1);
                tlast_q    <= word_last & (beats_left == NBEATS_W'(1));
            end
        end
    end

    assign bus.tvalid = (state_q == ST_SEND);
    assign bus.tdata  = tdata_q;
    assign bus.tlast  = tlast_q;
endmodule

// File: tb/tb_iob_axistream_out_w.sv
// Randomized bench with a queue-based reference model of the word unpacker,
// plus directed scenarios with hand-computed expectations.
module tb_iob_axistream_out_w;
    localparam int DATA_W     = 32;
    localparam int TDATA_W    = 8;
    localparam int ADDR_W     = 3;
    localparam int DEPTH_LOG2 = 2;
    localparam int R          = DATA_W / TDATA_W;
    localparam int DEPTH      = 1 << DEPTH_LOG2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    iob_axistream_out_w_if #(.DATA_W(DATA_W), .TDATA_W(TDATA_W), .ADDR_W(ADDR_W)) bus ();

    iob_axistream_out_w #(
        .DATA_W          (DATA_W),
        .TDATA_W         (TDATA_W),
        .FIFO_DEPTH_LOG2 (DEPTH_LOG2),
        .ADDR_W          (ADDR_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        bit          last;
        int          n;
        logic [31:0] d;
    } word_t;

    word_t       words[$];       // queued words, not yet taken by the unpacker
    logic [8:0]  beats[$];       // {tdata, tlast} still to be sent from the held word
    logic [8:0]  obs[$];         // beats the DUT actually handed over
    bit          m_en = 0;
    bit          m_ovf = 0;
    logic [5:0]  m_nb = '0;
    logic        e_ready = 1'b0;
    logic [31:0] e_rdata = '0;
    logic        last_tvalid = 1'b0;
    logic [8:0]  last_beat = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_read(input int a);
        logic [31:0] v;
        v = '0;
        case (a)
            2: v = {26'd0, m_nb};
            3: v = {31'd0, m_en};
            4: v = {16'(words.size()), 12'd0, m_ovf, beats.size() > 0,
                    words.size() == 0, words.size() == DEPTH};
            default: v = '0;
        endcase
        return v;
    endfunction

    function automatic void load_word(input word_t w);
        for (int k = 0; k < w.n; k++)
            beats.push_back({w.d[k*8 +: 8], w.last && (k == w.n - 1)});
    endfunction

    function automatic void model_step();
        bit          wr;
        bit          clr;
        int          a;
        word_t       w;
        logic [8:0]  tmp;
        if (last_tvalid && bus.tready)
            obs.push_back(last_beat);
        wr  = bus.valid && (bus.wstrb != 0);
        a   = int'(bus.address);
        clr = wr && (a == 3) && bus.wdata[1];
        e_ready = bus.valid;
        e_rdata = (bus.valid && !wr) ? model_read(a) : 32'd0;
        if (clr) begin
            words.delete();
            beats.delete();
        end else begin
            if (beats.size() > 0 && bus.tready)
                tmp = beats.pop_front();
            if (beats.size() == 0 && m_en && words.size() > 0)
                load_word(words.pop_front());
            if (wr && (a == 0 || a == 1)) begin
                w.last = (a == 1);
                w.n    = (a == 0 || m_nb == 0 || int'(m_nb) > R) ? R : int'(m_nb);
                w.d    = bus.wdata;
                if (words.size() == DEPTH)
                    m_ovf = 1;
                else
                    words.push_back(w);
            end
        end
        if (wr && a == 2)
            m_nb = bus.wdata[5:0];
        if (wr && a == 3) begin
            m_en = bus.wdata[0];
            if (bus.wdata[1])
                m_ovf = 0;
        end
    endfunction

    // Reference model advances on every edge; outputs compared just after it.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            words.delete();
            beats.delete();
            m_en = 0;
            m_ovf = 0;
            m_nb = '0;
            e_ready = 1'b0;
            e_rdata = '0;
            last_tvalid = 1'b0;
        end else begin
            model_step();
        end
        #1;
        chk("ready", 32'(bus.ready), 32'(e_ready));
        chk("rdata", bus.rdata, e_rdata);
        chk("tvalid", 32'(bus.tvalid), 32'(beats.size() > 0));
        chk("tlast", 32'(bus.tlast), (beats.size() > 0) ? 32'(beats[0][0]) : 32'd0);
        if (beats.size() > 0)
            chk("tdata", 32'(bus.tdata), 32'(beats[0][8:1]));
        if (!rst_n)
            chk("tdata_rst", 32'(bus.tdata), 32'd0);
        last_tvalid = bus.tvalid;
        last_beat   = {bus.tdata, bus.tlast};
    end

    task automatic cpu_write(input int a, input logic [31:0] d);
        @(negedge clk);
        bus.valid   = 1'b1;
        bus.address = ADDR_W'(a);
        bus.wdata   = d;
        bus.wstrb   = 4'hF;
        @(negedge clk);
        bus.valid   = 1'b0;
        bus.wstrb   = 4'h0;
    endtask

    task automatic cpu_read(input int a, output logic [31:0] v);
        @(negedge clk);
        bus.valid   = 1'b1;
        bus.address = ADDR_W'(a);
        bus.wstrb   = 4'h0;
        @(negedge clk);
        bus.valid   = 1'b0;
        chk("read_ready", 32'(bus.ready), 32'd1);
        v = bus.rdata;
    endtask

    task automatic wait_obs(input string name, input int target, input int budget);
        int i;
        i = 0;
        while (obs.size() < target && i < budget) begin
            @(negedge clk);
            i++;
        end
        chk(name, 32'(obs.size()), 32'(target));
    endtask

    task automatic chk_beat(input string name, input int idx, input logic [8:0] exp);
        logic [8:0] act;
        act = (idx < obs.size()) ? obs[idx] : 9'h1ff;
        chk(name, 32'(act), 32'(exp));
    endtask

    logic [31:0] v;
    logic [8:0]  e37 [4] = '{9'h022, 9'h044, 9'h066, 9'h088};
    logic [8:0]  e38 [3] = '{9'h1BA, 9'h198, 9'h177};
    int          gaps;
    bit          seen;

    initial begin
        bus.valid   = 1'b0;
        bus.address = '0;
        bus.wdata   = '0;
        bus.wstrb   = '0;
        bus.tready  = 1'b0;
        rst_n       = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_tvalid", 32'(bus.tvalid), 32'd0);
        chk("rst_tlast", 32'(bus.tlast), 32'd0);
        chk("rst_ready", 32'(bus.ready), 32'd0);
        chk("rst_rdata", bus.rdata, 32'd0);
        rst_n = 1'b1;
        cpu_read(4, v);
        chk("status_after_reset", v, 32'h0000_0002);
        cpu_read(2, v);
        chk("nbeats_after_reset", v, 32'd0);

        // Full word, always-ready sink, latency N+2
        bus.tready = 1'b1;
        cpu_write(3, 32'h1);
        obs.delete();
        cpu_write(0, 32'h4433_2211);
        chk("lat_n1_tvalid", 32'(bus.tvalid), 32'd0);
        @(negedge clk);
        chk("lat_n2_tvalid", 32'(bus.tvalid), 32'd1);
        wait_obs("word_beats", 4, 20);
        for (int k = 0; k < 4; k++)
            chk_beat($sformatf("word_beat%0d", k), k, e37[k]);

        // Short last word
        cpu_write(2, 32'd3);
        obs.delete();
        cpu_write(1, 32'hAABB_CCDD);
        wait_obs("last_beats", 3, 20);
        for (int k = 0; k < 3; k++)
            chk_beat($sformatf("last_beat%0d", k), k, e38[k]);
        repeat (4) @(negedge clk);
        chk("last_no_extra", 32'(obs.size()), 32'd3);

        // Two words with toggling sink
        obs.delete();
        bus.tready = 1'b0;
        cpu_write(0, 32'h0403_0201);
        cpu_write(0, 32'h0807_0605);
        seen = 0;
        gaps = 0;
        for (int i = 0; i < 100 && obs.size() < 8; i++) begin
            @(negedge clk);
            bus.tready = ~bus.tready;
            if (bus.tvalid)
                seen = 1;
            else if (seen && obs.size() < 8)
                gaps++;
        end
        chk("toggle_count", 32'(obs.size()), 32'd8);
        chk("toggle_no_bubble", 32'(gaps), 32'd0);
        for (int k = 0; k < 8; k++)
            chk_beat($sformatf("toggle_beat%0d", k), k, 9'((k + 1) * 2));

        // Overflow, level and clear
        bus.tready = 1'b1;
        cpu_write(3, 32'h0);
        for (int i = 0; i < 5; i++)
            cpu_write(0, 32'hA0A0_0000 + 32'(i));
        cpu_read(4, v);
        chk("status_full_ovf", v, 32'h0004_0009);
        bus.tready = 1'b0;
        cpu_write(3, 32'h1);
        cpu_read(4, v);
        chk("status_busy_l3", v, 32'h0003_000C);
        chk("held_tvalid", 32'(bus.tvalid), 32'd1);
        cpu_write(3, 32'h2);
        chk("clear_tvalid", 32'(bus.tvalid), 32'd0);
        cpu_read(4, v);
        chk("status_after_clear", v, 32'h0000_0002);

        // Reset in the middle of a frame
        cpu_write(3, 32'h1);
        obs.delete();
        cpu_write(0, 32'hDDCC_BBAA);
        for (int i = 0; i < 10 && !bus.tvalid; i++)
            @(negedge clk);
        bus.tready = 1'b1;
        @(negedge clk);
        bus.tready = 1'b0;
        chk("mid_beat2_tdata", 32'(bus.tdata), 32'h0000_00BB);
        chk_beat("mid_beat0", 0, 9'h154);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_tvalid", 32'(bus.tvalid), 32'd0);
        chk("mid_rst_tdata", 32'(bus.tdata), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cpu_read(4, v);
        chk("mid_rst_status", v, 32'h0000_0002);
        bus.tready = 1'b1;
        repeat (10) @(negedge clk);
        chk("mid_rst_no_output", 32'(obs.size()), 32'd1);
        chk("mid_rst_idle", 32'(bus.tvalid), 32'd0);

        // Randomized traffic against the model
        cpu_write(3, 32'h1);
        for (int c = 0; c < 3000; c++) begin
            int          sel;
            int          a;
            logic [31:0] d;
            @(negedge clk);
            bus.tready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1) == 1) begin
                sel = $urandom_range(0, 9);
                a = (sel < 3) ? 0 : (sel < 5) ? 1 : (sel == 5) ? 2 :
                    (sel == 6) ? 3 : (sel == 7) ? 4 : (sel == 8) ? 5 : 7;
                d = $urandom;
                if (a == 3)
                    d = {30'd0, ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0)};
                bus.valid   = 1'b1;
                bus.address = ADDR_W'(a);
                bus.wdata   = d;
                bus.wstrb   = ($urandom_range(0, 2) != 0) ? 4'($urandom_range(1, 15)) : 4'h0;
            end else begin
                bus.valid = 1'b0;
                bus.wstrb = 4'h0;
            end
        end
        @(negedge clk);
        bus.valid  = 1'b0;
        bus.wstrb  = 4'h0;
        bus.tready = 1'b1;
        cpu_write(3, 32'h1);
        repeat (60) @(negedge clk);
        cpu_read(4, v);
        chk("drain_status", v & 32'hFFFF_FFF7, 32'h0000_0002);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/iob_axistream_out_w.md
IOB_AXISTREAM_OUT_W -- requirements
Module: iob_axistream_out_w

Interface
Parameters, one per line: name, default, meaning.
REQ-001 SHALL have parameter DATA_W, 32, CPU data width.
REQ-002 SHALL have parameter TDATA_W, 8, stream beat width; DATA_W/TDATA_W = R beats per word, R a power of 2 (1..32).
REQ-003 SHALL have parameter FIFO_DEPTH_LOG2, 4, log2 of word FIFO depth.
REQ-004 SHALL have parameter ADDR_W, 3, CPU word-address width.

Ports, one per line: name, direction, width, meaning.
REQ-005 SHALL have port clk, in, 1, single clock; all logic on rising edge.
REQ-006 SHALL have port rst_n, in, 1, asynchronous active-low reset.
REQ-007 SHALL have port valid, in, 1, CPU request.
REQ-008 SHALL have port address, in, ADDR_W, register word offset.
REQ-009 SHALL have port wdata, in, DATA_W, write data.
REQ-010 SHALL have port wstrb, in, DATA_W/8, write strobes; nonzero means write.
REQ-011 SHALL have port rdata, out, DATA_W, read data.
REQ-012 SHALL have port ready, out, 1, request done.
REQ-013 SHALL have port tdata, out, TDATA_W, stream data.
REQ-014 SHALL have port tvalid, out, 1, stream valid.
REQ-015 SHALL have port tready, in, 1, sink ready.
REQ-016 SHALL have port tlast, out, 1, frame end.

Function
REQ-017 Register map (word offsets) SHALL be: 0 DATA (WO), 1 DATA_LAST (WO), 2 NBEATS (RW, [5:0]), 3 CTRL (RW: bit0 enable, bit1 clear, self-clearing), 4 STATUS (RO: bit0 full, bit1 empty, bit2 busy, bit3 overflow, [31:16] word level); other offsets read 0, writes ignored.
REQ-018 ready SHALL assert exactly one cycle after each valid cycle, for one cycle; rdata valid in that cycle.
REQ-019 Write to DATA SHALL push {last=0, nbeats=R, wdata} into the word FIFO.
REQ-020 Write to DATA_LAST SHALL push {last=1, nbeats=NBEATS, wdata}; NBEATS of 0 or >R SHALL be treated as R.
REQ-021 Push while full SHALL be dropped and set sticky overflow; CTRL.clear clears overflow.
REQ-022 Unpacker FSM SHALL have states IDLE (no word held) and SEND (word held, beat counter active).
REQ-023 IDLE->SEND when enable=1 and FIFO not empty; word popped in that transition.
REQ-024 Beats SHALL be emitted LSB-first: beat k = word[k*TDATA_W +: TDATA_W], k = 0..nbeats-1.
REQ-025 tlast SHALL be 1 only on beat nbeats-1 of a last=1 word.
REQ-026 Once tvalid=1, tvalid/tdata/tlast SHALL hold stable until tready=1 (except REQ-030).
REQ-027 On acceptance of final beat: if FIFO not empty and enable=1, next word loads the same cycle (no bubble); else SEND->IDLE.
REQ-028 Latency: word written with valid at cycle N (FIFO empty, IDLE, enabled) SHALL give tvalid=1 at cycle N+2.
REQ-029 enable=0 SHALL stop loading new words only; current word completes.
REQ-030 CTRL.clear SHALL empty FIFO, force IDLE, drop tvalid next cycle (abort, permitted protocol break); push in same cycle as clear is discarded.
REQ-031 busy = (state == SEND); level counts words in FIFO, excluding the held word.
REQ-032 Simultaneous push and pop SHALL keep level unchanged and be legal when full.

Reset
REQ-033 rst_n low SHALL asynchronously force: tvalid=0, tlast=0, tdata=0, ready=0, rdata=0, state IDLE, FIFO empty, NBEATS=0, enable=0, overflow=0.
REQ-034 Reset mid-frame SHALL abandon partial frame; no beat emitted before first write after reset.

Structure
REQ-035 Register offsets and CTRL/STATUS bit positions SHALL live in shared package iob_axistream_out_w_pkg.
REQ-036 Word FIFO SHALL be one sub-module iob_axistream_out_w_fifo (width DATA_W+7, show-ahead, async active-low reset); unpacker FSM and register file stay in top.

Verification
REQ-037 TDATA_W=8: enable, write DATA 0x44332211, tready=1 -> beats 11,22,33,44, tlast=0, tvalid at N+2.
REQ-038 NBEATS=3, write DATA_LAST 0xAABBCCDD -> beats DD,CC,BB, tlast=1 only on BB.
REQ-039 Two DATA writes, tready toggled 1,0,1... -> 8 beats in order, no bubble at word boundary, tdata stable while stalled.
REQ-040 FIFO_DEPTH_LOG2=2, enable=0, 5 writes -> STATUS full=1, level=4, overflow=1; clear -> level=0, overflow=0, tvalid=0.
REQ-041 rst_n low during beat 2 of 4 -> tvalid=0 immediately, busy=0; after release no output until new write.
